// File: rtl/fixed_gain_ramp.sv
// ============================================================================
//  Module   : fixed_gain_ramp
//  Purpose  : Two-stage streaming gain stage with slewed gain and saturation.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fixed_gain_ramp #(
    parameter int operand_size    = 32,
    parameter int fractional_size = 12,
    parameter int step_size       = 16,
    parameter int init_gain       = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [operand_size-1:0] target_gain,
    input  logic                    gain_load,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [operand_size-1:0] in_sample,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [operand_size-1:0] out_sample,
    output logic                    out_clip,
    output logic [operand_size-1:0] gain_now,
    output logic                    ramping
);

    localparam int c_PW = 2 * operand_size;
    localparam logic signed [c_PW-1:0] c_MAX =
        {{(c_PW-operand_size+1){1'b0}}, {(operand_size-1){1'b1}}};
    localparam logic signed [c_PW-1:0] c_MIN =
        {{(c_PW-operand_size+1){1'b1}}, {(operand_size-1){1'b0}}};
    localparam logic signed [operand_size:0]   c_STEP_D = (operand_size+1)'(step_size);
    localparam logic signed [operand_size-1:0] c_STEP_G = operand_size'(step_size);
    localparam logic [operand_size-1:0]        c_INIT   = operand_size'(init_gain);

    logic signed [operand_size-1:0] r_gain;
    logic signed [operand_size-1:0] r_target;
    logic                           r_s1_valid;
    logic signed [c_PW-1:0]         r_s1_prod;
    logic                           r_out_valid;
    logic [operand_size-1:0]        r_out_sample;
    logic                           r_out_clip;

    logic                           w_advance;
    logic                           w_accept;
    logic signed [c_PW-1:0]         w_in_ext;
    logic signed [c_PW-1:0]         w_gain_ext;
    logic signed [c_PW-1:0]         w_prod;
    logic signed [c_PW-1:0]         w_shifted;
    logic [operand_size-1:0]        w_sat;
    logic                           w_clip;
    logic signed [operand_size:0]   w_diff;
    logic signed [operand_size-1:0] w_gain_next;

    assign w_advance = !r_out_valid || out_ready;
    assign w_accept  = in_valid && w_advance;

    // Operands are sign-extended to full product width so nothing is lost before the shift.
    assign w_in_ext   = {{operand_size{in_sample[operand_size-1]}}, in_sample};
    assign w_gain_ext = {{operand_size{r_gain[operand_size-1]}}, r_gain};
    assign w_prod     = w_in_ext * w_gain_ext;
    assign w_shifted  = w_prod >>> fractional_size;

    always_comb begin
        w_sat  = r_s1_prod[operand_size-1:0];
        w_clip = 1'b0;
        if (r_s1_prod > c_MAX) begin
            w_sat  = c_MAX[operand_size-1:0];
            w_clip = 1'b1;
        end else if (r_s1_prod < c_MIN) begin
            w_sat  = c_MIN[operand_size-1:0];
            w_clip = 1'b1;
        end
    end

    // One extra bit keeps the difference exact across the full gain range.
    assign w_diff = {r_target[operand_size-1], r_target} - {r_gain[operand_size-1], r_gain};

    always_comb begin
        w_gain_next = r_gain;
        if ((w_diff <= c_STEP_D) && (w_diff >= -c_STEP_D)) begin
            w_gain_next = r_target;
        end else if (w_diff > 0) begin
            w_gain_next = r_gain + c_STEP_G;
        end else begin
            w_gain_next = r_gain - c_STEP_G;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_target <= c_INIT;
        end else if (gain_load) begin
            r_target <= target_gain;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gain <= c_INIT;
        end else if (w_accept) begin
            r_gain <= w_gain_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_prod    <= '0;
            r_out_valid  <= 1'b0;
            r_out_sample <= '0;
            r_out_clip   <= 1'b0;
        end else if (w_advance) begin
            r_s1_valid   <= in_valid;
            r_s1_prod    <= w_shifted;
            r_out_valid  <= r_s1_valid;
            r_out_sample <= w_sat;
            r_out_clip   <= w_clip;
        end
    end

    assign in_ready   = w_advance;
    assign out_valid  = r_out_valid;
    assign out_sample = r_out_sample;
    assign out_clip   = r_out_clip;
    assign gain_now   = r_gain;
    assign ramping    = (r_gain != r_target);

endmodule

`default_nettype wire

// File: tb/tb_fixed_gain_ramp.sv
// ============================================================================
//  Module   : tb_fixed_gain_ramp
//  Purpose  : Directed self-checking bench for fixed_gain_ramp.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fixed_gain_ramp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] target_gain = '0;
    logic        gain_load = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_sample = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_sample;
    logic        out_clip;
    logic [31:0] gain_now;
    logic        ramping;

    int n_checks = 0;
    int n_errors = 0;
    logic [32:0] q[$];

    fixed_gain_ramp dut (
        .clk        (clk),
        .rst        (rst),
        .target_gain(target_gain),
        .gain_load  (gain_load),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sample  (in_sample),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sample (out_sample),
        .out_clip   (out_clip),
        .gain_now   (gain_now),
        .ramping    (ramping)
    );

    always #5 clk = ~clk;

    // Record every output transfer as {clip, sample}.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) q.push_back({out_clip, out_sample});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_out_valid"},  out_valid,  0);
        check({tag, "_out_sample"}, out_sample, 0);
        check({tag, "_out_clip"},   out_clip,   0);
        check({tag, "_gain_now"},   gain_now,   4096);
        check({tag, "_ramping"},    ramping,    0);
        check({tag, "_in_ready"},   in_ready,   1);
    endtask

    task automatic load_gain(input logic [31:0] g);
        target_gain = g;
        gain_load   = 1'b1;
        tick();
        gain_load   = 1'b0;
    endtask

    task automatic send_one(input logic [31:0] s);
        in_valid  = 1'b1;
        in_sample = s;
        tick();
        in_valid  = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset("rst0");

        // Basic latency at unity gain
        in_valid  = 1'b1;
        in_sample = 32'd1000;
        tick();
        in_valid = 1'b0;
        check("lat_stage1_out_valid", out_valid, 0);
        tick();
        check("lat_out_valid", out_valid, 1);
        check("lat_out_sample", out_sample, 1000);
        check("lat_out_clip", out_clip, 0);
        check("lat_gain_now", gain_now, 4096);
        check("lat_ramping", ramping, 0);
        tick();
        q.delete();

        // Ramp 1.0 -> 2.0 with a constant input of 1000
        load_gain(32'd8192);
        check("ramp_start_ramping", ramping, 1);
        in_valid  = 1'b1;
        in_sample = 32'd1000;
        for (int k = 1; k <= 260; k++) begin
            tick();
            if (k == 255) begin
                check("ramp_255_ramping", ramping, 1);
                check("ramp_255_gain", gain_now, 8176);
            end
            if (k == 256) begin
                check("ramp_256_ramping", ramping, 0);
                check("ramp_256_gain", gain_now, 8192);
            end
        end
        in_valid = 1'b0;
        repeat (3) tick();
        check("ramp_count", q.size(), 260);
        if (q.size() == 260) begin
            check("ramp_q0", q[0], {1'b0, 32'd1000});
            check("ramp_q1", q[1], {1'b0, 32'd1003});
            check("ramp_q2", q[2], {1'b0, 32'd1007});
            check("ramp_q259", q[259], {1'b0, 32'd2000});
            for (int k = 0; k < 260; k++) begin
                longint g;
                longint e;
                g = 4096 + 16 * k;
                if (g > 8192) g = 8192;
                e = (1000 * g) >>> 12;
                check($sformatf("ramp_q%0d_model", k), q[k][31:0], e[31:0]);
            end
        end
        q.delete();

        // Saturation at gain 2.0
        in_valid  = 1'b1;
        in_sample = 32'h7FFF_FFFF;
        tick();
        in_sample = 32'h8000_0000;
        tick();
        in_sample = 32'hFFFF_FFFD;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("sat_count", q.size(), 3);
        if (q.size() == 3) begin
            check("sat_pos", q[0], {1'b1, 32'h7FFF_FFFF});
            check("sat_neg", q[1], {1'b1, 32'h8000_0000});
            check("sat_minus3", q[2], {1'b0, 32'hFFFF_FFFA});
        end
        q.delete();

        // Ramp down to 1.5, then check floor rounding of -4.5
        load_gain(32'd6144);
        in_valid  = 1'b1;
        in_sample = '0;
        repeat (128) tick();
        in_valid = 1'b0;
        check("down_gain", gain_now, 6144);
        check("down_ramping", ramping, 0);
        repeat (3) tick();
        q.delete();
        send_one(32'hFFFF_FFFD);
        repeat (3) tick();
        check("floor_count", q.size(), 1);
        if (q.size() == 1) check("floor_minus3", q[0], {1'b0, 32'hFFFF_FFFB});
        q.delete();

        // Back-pressure mid-stream while ramping toward 2.0
        load_gain(32'd8192);
        begin
            int cyc;
            int sent;
            cyc  = 0;
            sent = 0;
            in_sample = 32'd4096;
            while (sent < 8 && cyc < 100) begin
                out_ready = !(cyc >= 3 && cyc < 8);
                in_valid  = 1'b1;
                @(negedge clk);
                if (in_ready) sent++;
                if (cyc == 6) begin
                    check("stall_in_ready", in_ready, 0);
                    check("stall_out_valid", out_valid, 1);
                    check("stall_gain", gain_now, 6192);
                end
                @(posedge clk);
                #1;
                cyc++;
            end
            check("stall_sent", sent, 8);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        check("stall_gain_end", gain_now, 6272);
        check("stall_count", q.size(), 8);
        if (q.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                logic [31:0] e;
                e = 32'd6144 + 32'd16 * k;
                check($sformatf("stall_q%0d", k), q[k], {1'b0, e});
            end
        end

        // Reset during a stall
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("rst1");
        load_gain(32'd8192);
        in_valid  = 1'b1;
        in_sample = 32'd1000;
        repeat (10) tick();
        check("pre_rst_gain", gain_now, 4256);
        in_sample = 32'd555;
        out_ready = 1'b0;
        repeat (3) tick();
        check("pre_rst_blocked", in_ready, 0);
        #2 rst = 1'b1;
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_reset("rst2");
        tick();
        rst = 1'b0;
        q.delete();
        send_one(32'd1000);
        repeat (3) tick();
        check("post_rst_count", q.size(), 1);
        if (q.size() == 1) check("post_rst_sample", q[0], {1'b0, 32'd1000});
        check("post_rst_gain", gain_now, 4096);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
